// File: rtl/fp_vector_accumulator_fp32_8_if.sv
// Beat-in / sum-out bundle for the FP32_8 vector accumulator.
// master drives beats and out_ready; slave is the accumulator.
interface fp_vector_accumulator_fp32_8_if #(
    parameter int LENGTH = 4
);
    logic [LENGTH-1:0][31:0] data_in;
    logic                    in_valid;
    logic                    in_ready;
    logic                    last_in;
    logic [31:0]             data_out;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output data_in, in_valid, last_in, out_ready,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, last_in, out_ready,
        output in_ready, data_out, out_valid
    );
endinterface

// File: rtl/fp_vector_accumulator_fp32_8.sv
// Serially sums every FP32_8 element of a packet of beats, one add per cycle, truncating FP add.
// A last beat produces its sum LENGTH cycles after accept; output held until out_ready.
module fp_vector_accumulator_fp32_8 #(
    parameter int LENGTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic debugen_in,
    fp_vector_accumulator_fp32_8_if.slave bus
);
    localparam int IDXW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUM  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [31:0]             acc_q, acc_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [LENGTH-1:0][31:0] vec_q, vec_d;
    logic                    last_q, last_d;
    logic                    in_fire, out_fire;

    // Subnormals read as zero, exponent 255 is infinity, guard bits truncated.
    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, sg;
        logic [7:0]  ea, eb, eg, es, diff;
        logic [26:0] mg, ms, norm;
        logic [27:0] sum;
        logic [4:0]  lz;
        logic        found;
        logic signed [9:0] er;
        logic [31:0] r;
        sa = a[31]; sb = b[31];
        ea = a[30:23]; eb = b[30:23];
        sg = 1'b0; eg = 8'h0; es = 8'h0; diff = 8'h0;
        mg = 27'h0; ms = 27'h0; norm = 27'h0; sum = 28'h0;
        lz = 5'd0; found = 1'b0; er = 10'sd0; r = 32'h0;
        if (ea == 8'hFF && eb == 8'hFF) begin
            r = (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7F80_0000;
        end else if (ea == 8'hFF) begin
            r = {sa, 8'hFF, 23'h0};
        end else if (eb == 8'hFF) begin
            r = {sb, 8'hFF, 23'h0};
        end else if (ea == 8'h0 && eb == 8'h0) begin
            r = 32'h0;
        end else if (ea == 8'h0) begin
            r = b;
        end else if (eb == 8'h0) begin
            r = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                sg = sa; eg = ea; es = eb;
                mg = {1'b1, a[22:0], 3'b000};
                ms = {1'b1, b[22:0], 3'b000};
            end else begin
                sg = sb; eg = eb; es = ea;
                mg = {1'b1, b[22:0], 3'b000};
                ms = {1'b1, a[22:0], 3'b000};
            end
            diff = eg - es;
            ms   = (diff >= 8'd27) ? 27'h0 : (ms >> diff);
            sum  = (sa == sb) ? ({1'b0, mg} + {1'b0, ms}) : ({1'b0, mg} - {1'b0, ms});
            if (sum == 28'h0) begin
                r = 32'h0;
            end else begin
                if (sum[27]) begin
                    norm = sum[27:1];
                    er   = $signed({2'b00, eg}) + 10'sd1;
                end else begin
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (sum[i]) found = 1'b1;
                            else        lz = lz + 5'd1;
                        end
                    end
                    norm = sum[26:0] << lz;
                    er   = $signed({2'b00, eg}) - $signed({5'b00000, lz});
                end
                if (er >= 10'sd255)    r = {sg, 8'hFF, 23'h0};
                else if (er <= 10'sd0) r = 32'h0;
                else                   r = {sg, er[7:0], norm[25:3]};
            end
        end
        return r;
    endfunction

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.data_out  = (state_q == S_DONE) ? acc_q : 32'h0;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    vec_d   = bus.data_in;
                    last_d  = bus.last_in;
                    idx_d   = '0;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                acc_d = fpadd(acc_q, vec_q[idx_q]);
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(LENGTH - 1)) begin
                    idx_d   = '0;
                    // A non-last beat keeps the running sum for the next beat.
                    state_d = last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (out_fire) begin
                    acc_d   = 32'h0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= 32'h0;
            idx_q   <= '0;
            vec_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && debugen_in) begin
            if (in_fire)  $write("%m: beat: %x last: %x\n", bus.data_in, bus.last_in);
            if (out_fire) $write("%m: sum: %x\n", bus.data_out);
        end
    end
endmodule
